// File: rtl/product_accumulator.sv
// Sums TERMS consecutive 8-bit products into one ACC_W-bit result behind a valid/ready port.
// Define PRODUCT_ACCUMULATOR_SAT_EN to saturate on overflow; the default build wraps modulo 2^ACC_W.
module product_accumulator #(
  parameter int ACC_W = 16,
  parameter int TERMS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic [7:0]       prod,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res,
  output logic             res_ovf
);
  // state | meaning
  // ACCUM | accepting products into the running sum
  // HOLD  | result presented, waiting for res_ready or clr
  localparam int CNT_W = (TERMS > 1) ? $clog2(TERMS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TERMS - 1);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [ACC_W:0]   sum;
  logic             carry, accept, last;

  assign sum   = {1'b0, acc} + {{(ACC_W-7){1'b0}}, prod};
  assign carry = sum[ACC_W];

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
  // Once at all-ones, any further nonzero term carries again, so saturation sticks.
  assign acc_nxt = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_nxt = sum[ACC_W-1:0];
`endif

  assign last      = (cnt == CNT_LAST);
  assign res_valid = (state == HOLD);

  always_comb begin
    state_nxt  = state;
    prod_ready = (state == ACCUM) && !clr;
    accept     = prod_valid && prod_ready;
    case (state)
      ACCUM:   if (accept && last) state_nxt = HOLD;
      HOLD:    if (clr || res_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      res     <= '0;
      res_ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      if (last) begin
        res     <= acc_nxt;
        res_ovf <= ovf | carry;
        acc     <= '0;
        cnt     <= '0;
        ovf     <= 1'b0;
      end else begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
        ovf <= ovf | carry;
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three instances (16b/4 terms, 9b/4 terms, 16b/1 term) share one stimulus.
// A sum-of-products model checks every cycle; directed literals pin the model.
module tb_product_accumulator;
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, clr, prod_valid, res_ready;
  logic [7:0] prod;

  logic pr0, rv0, ro0, pr9, rv9, ro9, pr1, rv1, ro1;
  logic [15:0] r0, r1;
  logic [8:0]  r9;

  always #5 clk = ~clk;

  product_accumulator #(.ACC_W(16), .TERMS(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .prod_valid(prod_valid), .prod_ready(pr0),
    .prod(prod), .res_valid(rv0), .res_ready(res_ready), .res(r0), .res_ovf(ro0));
  product_accumulator #(.ACC_W(9), .TERMS(4)) dut9 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .prod_valid(prod_valid), .prod_ready(pr9),
    .prod(prod), .res_valid(rv9), .res_ready(res_ready), .res(r9), .res_ovf(ro9));
  product_accumulator #(.ACC_W(16), .TERMS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .prod_valid(prod_valid), .prod_ready(pr1),
    .prod(prod), .res_valid(rv1), .res_ready(res_ready), .res(r1), .res_ovf(ro1));

  logic [15:0] r_a [3];
  logic        pr_a [3];
  logic        rv_a [3];
  logic        ro_a [3];
  assign r_a[0] = r0;
  assign r_a[1] = {7'b0, r9};
  assign r_a[2] = r1;
  assign pr_a[0] = pr0; assign pr_a[1] = pr9; assign pr_a[2] = pr1;
  assign rv_a[0] = rv0; assign rv_a[1] = rv9; assign rv_a[2] = rv1;
  assign ro_a[0] = ro0; assign ro_a[1] = ro9; assign ro_a[2] = ro1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Model: per instance, the true (unbounded) sum of the products taken since the last result.
  int     m_w [3] = '{16, 9, 16};
  int     m_t [3] = '{4, 4, 1};
  longint m_sum [3];
  int     m_cnt [3];
  bit     m_hold [3];
  longint m_res [3];
  bit     m_ovf [3];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_sum[k] = 0; m_cnt[k] = 0; m_hold[k] = 0; m_res[k] = 0; m_ovf[k] = 0;
      end else if (clr) begin
        m_sum[k] = 0; m_cnt[k] = 0; m_hold[k] = 0;
      end else if (!m_hold[k] && prod_valid) begin
        m_sum[k] += longint'(prod);
        m_cnt[k]++;
        if (m_cnt[k] == m_t[k]) begin
          longint lim;
          lim = longint'(1) << m_w[k];
          m_ovf[k] = (m_sum[k] >= lim);
          m_res[k] = !m_ovf[k] ? m_sum[k] : (SAT ? lim - 1 : m_sum[k] % lim);
          m_hold[k] = 1;
          m_sum[k] = 0;
          m_cnt[k] = 0;
        end
      end else if (m_hold[k] && res_ready) begin
        m_hold[k] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("res_valid[%0d]", k), 64'(rv_a[k]), 64'(m_hold[k]));
        check($sformatf("prod_ready[%0d]", k), 64'(pr_a[k]), 64'(!m_hold[k] && !clr));
        check($sformatf("res[%0d]", k), 64'(r_a[k]), 64'(m_res[k]));
        check($sformatf("res_ovf[%0d]", k), 64'(ro_a[k]), 64'(m_ovf[k]));
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] p, input logic rr, input logic c);
    prod_valid = v; prod = p; res_ready = rr; clr = c;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; prod_valid = 1'b0; prod = 8'd0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    repeat (10) drive(0, 0, 1, 0);
    check("idle_res", 64'(r0), 64'd0);
    check("idle_ready", 64'(pr0), 64'd1);
    check("idle_valid", 64'(rv0), 64'd0);

    drive(1, 15, 1, 0);
    check("t1_res", 64'(r1), 64'd15);
    check("t1_valid", 64'(rv1), 64'd1);
    drive(1, 225, 1, 0);
    drive(1, 0, 1, 0);
    drive(1, 100, 1, 0);
    check("basic_valid", 64'(rv0), 64'd1);
    check("basic_res", 64'(r0), 64'd340);
    check("basic_ovf", 64'(ro0), 64'd0);
    check("basic_hold_ready", 64'(pr0), 64'd0);
    drive(0, 0, 1, 0);
    check("basic_release", 64'(rv0), 64'd0);
    check("basic_ready_back", 64'(pr0), 64'd1);

    drive(1, 15, 1, 0);
    drive(1, 225, 1, 0);
    drive(1, 0, 1, 0);
    drive(1, 100, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 7, 0, 0);
      check("bp_res", 64'(r0), 64'd340);
      check("bp_ready", 64'(pr0), 64'd0);
    end
    drive(1, 7, 1, 0);
    check("bp_release", 64'(rv0), 64'd0);
    drive(1, 7, 1, 0);
    drive(1, 1, 1, 0);
    drive(1, 1, 1, 0);
    drive(1, 1, 1, 0);
    check("bp_fifth_once", 64'(r0), 64'd10);
    drive(0, 0, 1, 0);

    drive(1, 10, 1, 0);
    drive(0, 0, 1, 0);
    drive(1, 20, 1, 0);
    drive(0, 0, 1, 1);
    drive(1, 1, 1, 0);
    drive(1, 2, 1, 0);
    drive(1, 3, 1, 0);
    drive(1, 4, 1, 0);
    check("clr_res", 64'(r0), 64'd10);
    check("clr_valid", 64'(rv0), 64'd1);
    drive(0, 0, 1, 0);

    repeat (4) drive(1, 5, 0, 0);
    check("hold_res", 64'(r0), 64'd20);
    drive(0, 0, 0, 1);
    check("hold_clr_valid", 64'(rv0), 64'd0);
    check("hold_clr_res", 64'(r0), 64'd20);
    drive(0, 0, 1, 0);

    repeat (4) drive(1, 225, 1, 0);
    check("ovf9_res", 64'(r9), SAT ? 64'd511 : 64'd388);
    check("ovf9_flag", 64'(ro9), 64'd1);
    check("ovf16_res", 64'(r0), 64'd900);
    check("ovf16_flag", 64'(ro0), 64'd0);
    drive(0, 0, 1, 0);

    drive(1, 50, 1, 0);
    drive(1, 60, 1, 0);
    prod_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_res", 64'(r0), 64'd0);
    check("arst_valid", 64'(rv9), 64'd0);
    check("arst_ovf", 64'(ro9), 64'd0);
    #1 rst_n = 1'b1;
    repeat (4) drive(1, 1, 1, 0);
    check("arst_sum", 64'(r0), 64'd4);
    check("arst_sum_valid", 64'(rv0), 64'd1);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
